// File: rtl/pe_pkg.sv
// Shared types and helpers for the PE-array window feeder: FSM states,
// kernel half-width, counter sizing and window packing.
package pe_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        TAIL   = 2'd2,
        FLUSH  = 2'd3
    } feeder_state_e;

    // Window packing: pixel c (0 = leftmost) sits at [c*DATA_WIDTH +: DATA_WIDTH].
    localparam int WIN_LEFTMOST_IDX = 0;

    function automatic int half_kernel(input int k);
        return k / 2;
    endfunction

    // Bits needed for a counter spanning 0..n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int win_lsb(input int c, input int dw);
        return (c - WIN_LEFTMOST_IDX) * dw;
    endfunction

endpackage

// File: rtl/window_shift_reg.sv
// DEPTH-entry pixel shift register: new pixel enters at the rightmost slot,
// older pixels move left. load_zero takes priority over shift_en.
module window_shift_reg
    import pe_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_zero,
    input  logic                        shift_en,
    input  logic [DATA_WIDTH-1:0]       din,
    output logic [DEPTH*DATA_WIDTH-1:0] data_o
);

    logic [DEPTH*DATA_WIDTH-1:0] data_q;
    logic [DEPTH*DATA_WIDTH-1:0] data_d;
    logic [DEPTH*DATA_WIDTH-1:0] shifted;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        if (gi == DEPTH - 1) begin : g_in
            assign shifted[win_lsb(gi, DATA_WIDTH) +: DATA_WIDTH] = din;
        end else begin : g_move
            assign shifted[win_lsb(gi, DATA_WIDTH) +: DATA_WIDTH] =
                data_q[win_lsb(gi + 1, DATA_WIDTH) +: DATA_WIDTH];
        end
    end

    always_comb begin
        data_d = data_q;
        if (load_zero) begin
            data_d = '0;
        end else if (shift_en) begin
            data_d = shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/pe_window_feeder.sv
// Raster pixel stream -> zero-padded horizontal windows for the PE array,
// with drain windows at frame end. PE_WINDOW_FEEDER_BINARIZE_EN thresholds pixels to 0/1.
module pe_window_feeder
    import pe_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int IMG_WIDTH   = 16,
    parameter int IMG_HEIGHT  = 16,
    parameter int THRESHOLD   = 128
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [DATA_WIDTH-1:0]             s_data,
    input  logic                              pe_ready,
    output logic                              pe_en,
    output logic [DATA_WIDTH*KERNEL_SIZE-1:0] pe_data,
    output logic                              row_done,
    output logic                              frame_done
);

    localparam int P     = half_kernel(KERNEL_SIZE);
    localparam int WIN_W = DATA_WIDTH * KERNEL_SIZE;
    localparam int CW    = cnt_width(IMG_WIDTH);
    localparam int RW    = cnt_width(IMG_HEIGHT);
    localparam int SW    = cnt_width(KERNEL_SIZE);

    localparam logic [CW-1:0] COL_FILL_LAST = CW'(P - 1);
    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 1);
    localparam logic [SW-1:0] TAIL_LAST     = SW'(P - 1);
    localparam logic [SW-1:0] FLUSH_LAST    = SW'(KERNEL_SIZE - 2);

    feeder_state_e   state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [SW-1:0]   step_q, step_d;
    logic            pe_en_q, pe_en_d;
    logic [WIN_W-1:0] pe_data_q, pe_data_d;
    logic            row_done_q, row_done_d;
    logic            frame_done_q, frame_done_d;

    logic                  accept;
    logic [DATA_WIDTH-1:0] pix_in;
    logic                  shreg_load_zero;
    logic                  shreg_shift;
    logic [DATA_WIDTH-1:0] shreg_din;
    logic [WIN_W-1:0]      shreg_data;

    // Held low during reset so no pixel is taken while the frame is being abandoned.
    assign s_ready = ~rst & pe_ready & ((state_q == FILL) || (state_q == STREAM));
    assign accept  = s_valid & s_ready;

`ifdef PE_WINDOW_FEEDER_BINARIZE_EN
    localparam logic [DATA_WIDTH-1:0] THRESH = DATA_WIDTH'(THRESHOLD);
    assign pix_in = (s_data >= THRESH) ? DATA_WIDTH'(1) : '0;
`else
    assign pix_in = s_data;
`endif

    window_shift_reg #(
        .DEPTH      (KERNEL_SIZE),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shreg (
        .clk       (clk),
        .rst       (rst),
        .load_zero (shreg_load_zero),
        .shift_en  (shreg_shift),
        .din       (shreg_din),
        .data_o    (shreg_data)
    );

    always_comb begin
        state_d         = state_q;
        col_d           = col_q;
        row_d           = row_q;
        step_d          = step_q;
        pe_en_d         = 1'b0;
        pe_data_d       = '0;
        row_done_d      = 1'b0;
        frame_done_d    = 1'b0;
        shreg_load_zero = 1'b0;
        shreg_shift     = 1'b0;
        shreg_din       = '0;

        case (state_q)
            FILL: begin
                if (accept) begin
                    shreg_shift = 1'b1;
                    shreg_din   = pix_in;
                    col_d       = col_q + 1'b1;
                    if (col_q == COL_FILL_LAST) begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (accept) begin
                    shreg_shift = 1'b1;
                    shreg_din   = pix_in;
                    pe_en_d     = 1'b1;
                    pe_data_d   = {pix_in, shreg_data[WIN_W-1:DATA_WIDTH]};
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        step_d  = '0;
                        state_d = TAIL;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            TAIL: begin
                if (pe_ready) begin
                    shreg_shift = 1'b1;
                    pe_en_d     = 1'b1;
                    pe_data_d   = {{DATA_WIDTH{1'b0}}, shreg_data[WIN_W-1:DATA_WIDTH]};
                    if (step_q == TAIL_LAST) begin
                        // The emitted window uses the pre-update contents, so zeroing here is safe.
                        row_done_d      = 1'b1;
                        step_d          = '0;
                        shreg_load_zero = 1'b1;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = FLUSH;
                        end else begin
                            row_d   = row_q + 1'b1;
                            state_d = FILL;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (pe_ready) begin
                    pe_en_d = 1'b1;
                    if (step_q == FLUSH_LAST) begin
                        frame_done_d    = 1'b1;
                        step_d          = '0;
                        shreg_load_zero = 1'b1;
                        state_d         = FILL;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            col_q        <= '0;
            row_q        <= '0;
            step_q       <= '0;
            pe_en_q      <= 1'b0;
            pe_data_q    <= '0;
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            step_q       <= step_d;
            pe_en_q      <= pe_en_d;
            pe_data_q    <= pe_data_d;
            row_done_q   <= row_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pe_en      = pe_en_q;
    assign pe_data    = pe_data_q;
    assign row_done   = row_done_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pe_window_feeder.sv
// Directed bench for pe_window_feeder with a 4x2 image and a 3-pixel kernel.
module tb_pe_window_feeder;

    localparam int K  = 3;
    localparam int DW = 8;
    localparam int IW = 4;
    localparam int IH = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           s_valid;
    logic           s_ready;
    logic [DW-1:0]  s_data;
    logic           pe_ready;
    logic           pe_en;
    logic [DW*K-1:0] pe_data;
    logic           row_done;
    logic           frame_done;

    int checks = 0;
    int errors = 0;

    // Captured windows: {row_done, frame_done, pe_data}
    logic [DW*K+1:0] cap[$];

    localparam logic [25:0] EXP_FRAME [10] = '{
        26'h0020100, 26'h0030201, 26'h0040302, 26'h2000403,
        26'h0060500, 26'h0070605, 26'h0080706, 26'h2000807,
        26'h0000000, 26'h1000000
    };
    localparam logic [25:0] EXP_ROW [10] = '{
        26'h0020100, 26'h0030201, 26'h0040302, 26'h2000403,
        26'h0000000, 26'h0000000, 26'h0000000, 26'h2000000,
        26'h0000000, 26'h1000000
    };
`ifdef PE_WINDOW_FEEDER_BINARIZE_EN
    localparam logic [25:0] EXP_BIN [10] = '{
        26'h0010000, 26'h0000100, 26'h0010001, 26'h2000100,
        26'h0000000, 26'h0000000, 26'h0000000, 26'h2000000,
        26'h0000000, 26'h1000000
    };
`else
    localparam logic [25:0] EXP_BIN [10] = '{
        26'h0800000, 26'h07F8000, 26'h0FF7F80, 26'h200FF7F,
        26'h0000000, 26'h0000000, 26'h0000000, 26'h2000000,
        26'h0000000, 26'h1000000
    };
`endif

    localparam logic [7:0] PIX_FRAME [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    localparam logic [7:0] PIX_ROW   [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    localparam logic [7:0] PIX_BIN   [8] = '{8'h00, 8'h80, 8'h7F, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};

    always #5 clk = ~clk;

    pe_window_feeder #(
        .KERNEL_SIZE (K),
        .DATA_WIDTH  (DW),
        .IMG_WIDTH   (IW),
        .IMG_HEIGHT  (IH),
        .THRESHOLD   (128)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .pe_ready   (pe_ready),
        .pe_en      (pe_en),
        .pe_data    (pe_data),
        .row_done   (row_done),
        .frame_done (frame_done)
    );

    always @(negedge clk) begin
        if (pe_en) cap.push_back({row_done, frame_done, pe_data});
    end

    // Drives n_pix pixels from negedge to negedge; optional idle gap after
    // each accept and 3-cycle pe_ready stalls after accepts stall_a / stall_b.
    task automatic push_pixels(input logic [7:0] pix [8], input int n_pix, input bit gap,
                               input int stall_a, input int stall_b);
        bit acc;
        for (int i = 0; i < n_pix; i++) begin
            s_valid = 1'b1;
            s_data  = pix[i];
            acc     = 1'b0;
            for (int n = 0; n < 50 && !acc; n++) begin
                #1;
                acc = s_ready;
                @(posedge clk);
                @(negedge clk);
            end
            s_valid = 1'b0;
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL accept_px%0d s_ready got 0 required 1 within 50 cycles", i);
            end
            if (gap) begin
                @(posedge clk);
                @(negedge clk);
            end
            if (i == stall_a || i == stall_b) begin
                pe_ready = 1'b0;
                repeat (3) begin
                    @(posedge clk);
                    @(negedge clk);
                    #1;
                    checks++;
                    if (s_ready !== 1'b0 || pe_en !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_after_px%0d s_ready=%b pe_en=%b required 0 0", i, s_ready, pe_en);
                    end
                end
                pe_ready = 1'b1;
            end
        end
    endtask

    task automatic wait_frame_done(input string name);
        bit seen = 1'b0;
        s_valid = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            #1;
            if (cap.size() > 0 && cap[cap.size()-1][24]) seen = 1'b1;
        end
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s frame_done got none required pulse within 60 cycles", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_data = '0; pe_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({pe_en, pe_data, row_done, frame_done, s_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got en=%b data=%h rd=%b fd=%b rdy=%b required all 0",
                     pe_en, pe_data, row_done, frame_done, s_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_fill_ready s_ready got %b required 1", s_ready);
        end
        pe_ready = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_follows_pe s_ready got %b required 0", s_ready);
        end
        pe_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_row();
        cap.delete();
        push_pixels(PIX_ROW, 8, 1'b0, -1, -1);
        wait_frame_done("single_row");
        checks++;
        if (cap.size() != 10) begin
            errors++;
            $display("FAIL single_row count got %0d required 10", cap.size());
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= cap.size() || cap[i] !== EXP_ROW[i]) begin
                errors++;
                $display("FAIL single_row win%0d got %h required %h", i, (i < cap.size()) ? cap[i] : 26'h0, EXP_ROW[i]);
            end
        end
    endtask

    task automatic test_full_frame();
        cap.delete();
        push_pixels(PIX_FRAME, 8, 1'b0, -1, -1);
        wait_frame_done("full_frame");
        checks++;
        if (cap.size() != 10) begin
            errors++;
            $display("FAIL full_frame count got %0d required 10", cap.size());
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= cap.size() || cap[i] !== EXP_FRAME[i]) begin
                errors++;
                $display("FAIL full_frame win%0d got %h required %h", i, (i < cap.size()) ? cap[i] : 26'h0, EXP_FRAME[i]);
            end
        end
    endtask

    // Stall mid-STREAM of row 0, and again right after the last pixel of row 0 (TAIL hold).
    task automatic test_stall();
        cap.delete();
        push_pixels(PIX_FRAME, 8, 1'b0, 2, 3);
        wait_frame_done("stall");
        checks++;
        if (cap.size() != 10) begin
            errors++;
            $display("FAIL stall count got %0d required 10", cap.size());
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= cap.size() || cap[i] !== EXP_FRAME[i]) begin
                errors++;
                $display("FAIL stall win%0d got %h required %h", i, (i < cap.size()) ? cap[i] : 26'h0, EXP_FRAME[i]);
            end
        end
    endtask

    task automatic test_gap();
        cap.delete();
        push_pixels(PIX_FRAME, 8, 1'b1, -1, -1);
        wait_frame_done("gap");
        checks++;
        if (cap.size() != 10) begin
            errors++;
            $display("FAIL gap count got %0d required 10", cap.size());
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= cap.size() || cap[i] !== EXP_FRAME[i]) begin
                errors++;
                $display("FAIL gap win%0d got %h required %h", i, (i < cap.size()) ? cap[i] : 26'h0, EXP_FRAME[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        push_pixels(PIX_FRAME, 6, 1'b0, -1, -1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({pe_en, pe_data, row_done, frame_done, s_ready} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got en=%b data=%h rd=%b fd=%b rdy=%b required all 0",
                     pe_en, pe_data, row_done, frame_done, s_ready);
        end
        rst = 1'b0;
        cap.delete();
        push_pixels(PIX_FRAME, 8, 1'b0, -1, -1);
        wait_frame_done("reset_mid");
        checks++;
        if (cap.size() != 10) begin
            errors++;
            $display("FAIL reset_mid count got %0d required 10", cap.size());
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= cap.size() || cap[i] !== EXP_FRAME[i]) begin
                errors++;
                $display("FAIL reset_mid win%0d got %h required %h", i, (i < cap.size()) ? cap[i] : 26'h0, EXP_FRAME[i]);
            end
        end
    endtask

    task automatic test_binarize();
        cap.delete();
        push_pixels(PIX_BIN, 8, 1'b0, -1, -1);
        wait_frame_done("binarize");
        checks++;
        if (cap.size() != 10) begin
            errors++;
            $display("FAIL binarize count got %0d required 10", cap.size());
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= cap.size() || cap[i] !== EXP_BIN[i]) begin
                errors++;
                $display("FAIL binarize win%0d got %h required %h", i, (i < cap.size()) ? cap[i] : 26'h0, EXP_BIN[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_full_frame();
        test_stall();
        test_gap();
        test_reset_mid_frame();
        test_binarize();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_window_feeder.md
Name: pe_window_feeder

Overview:
- Upstream producer for the PE array wrapper. Takes a raster-order pixel stream with a valid/ready handshake and emits one horizontal window of KERNEL_SIZE pixels per cycle on the array's `dataIn`/`en` interface.
- Pads the left and right image edges with zeros.
- At frame end, emits KERNEL_SIZE-1 all-zero drain windows so the vertical pixel pipeline flushes.

Parameters:
- KERNEL_SIZE, 3, window width in pixels; odd, ≥3; P = KERNEL_SIZE/2.
- DATA_WIDTH, 8, pixel width.
- IMG_WIDTH, 16, pixels per row; ≥ KERNEL_SIZE.
- IMG_HEIGHT, 16, rows per frame; ≥1.
- THRESHOLD, 128, binarize threshold; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input pixel accepted when s_valid & s_ready.
- s_data  in  DATA_WIDTH  input pixel, raster order.
- pe_ready  in  1  PE array can accept a window.
- pe_en  out  1  window valid; drives array `en`.
- pe_data  out  DATA_WIDTH*KERNEL_SIZE  window; pixel c (0 = leftmost) at [c*DATA_WIDTH +: DATA_WIDTH].
- row_done  out  1  one-cycle pulse with the last window of each image row.
- frame_done  out  1  one-cycle pulse with the last drain window.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - Outputs: pe_en=0, pe_data=0, row_done=0, frame_done=0, s_ready=0.
  - Internal: shift register cleared to zeros; column and row counters = 0; state = FILL.
  - Reset mid-frame abandons the frame. Nothing is emitted until a new frame starts from pixel 0.
- Shift register: KERNEL_SIZE entries. A new pixel (or a zero during TAIL) enters at the rightmost position; older entries shift left.
- s_ready = pe_ready when state is FILL or STREAM; otherwise 0. Combinational from state and pe_ready.
- Handshake: a pixel is accepted on any edge with s_valid & s_ready. Gaps in s_valid insert idle cycles with pe_en=0.
- All outputs are registered. A window is emitted the cycle after the handshake (or internal step) that completes it. Latency from rightmost pixel accepted to pe_en = 1 cycle.
- pe_ready=0 stalls everything: no accept, no state/counter advance, no emission, pe_en=0 that cycle. The array consumes pe_data only when pe_en=1.
- FSM:
  - FILL: accept P pixels of the row with no emission; the shift register holds P leading zeros. After the P-th accept -> STREAM.
  - STREAM: each accept emits a window centred on column x=col-P. When the row's last pixel (col=IMG_WIDTH-1) is accepted -> TAIL.
  - TAIL: each cycle with pe_ready=1, shift in a zero and emit, P times. The last emission asserts row_done. Then FILL if more rows remain, else FLUSH.
  - FLUSH: emit KERNEL_SIZE-1 windows of all zeros with pe_en=1. The last one asserts frame_done. Then FILL with the row counter at 0 and the shift register zeroed.
- Entering FILL always reloads the shift register with zeros, so windows never span rows.
- Per row: exactly IMG_WIDTH windows. Per frame: IMG_WIDTH*IMG_HEIGHT + KERNEL_SIZE-1 windows.
- Counters: col ranges 0..IMG_WIDTH-1 and wraps to 0 at row end; row ranges 0..IMG_HEIGHT-1 and wraps to 0 at frame end.
- IMG_HEIGHT=1: TAIL goes directly to FLUSH.
- Simultaneous last-pixel accept and pe_ready drop on the next cycle: TAIL holds until pe_ready returns; no window is lost or duplicated.

Optional Feature:
- Macro PE_WINDOW_FEEDER_BINARIZE_EN.
- Defined: each accepted pixel is replaced before the shift register by 1 if s_data >= THRESHOLD, else 0. This gives an occupancy map for OR-style inflation. Padding and drain values stay 0.
- Undefined: pixels pass unmodified. THRESHOLD is ignored.

Decomposition:
- Shared package pe_pkg:
  - State enum (FILL, STREAM, TAIL, FLUSH).
  - Function computing P = KERNEL_SIZE/2.
  - Counter-width helper (clog2-based).
  - Window-packing localparam conventions shared with the PE wrapper.
- One natural sub-module: window_shift_reg. It is a KERNEL_SIZE-deep, DATA_WIDTH-wide shift register with load-zero, shift-in and hold controls, and a flat packed output.

Test Plan (KERNEL_SIZE=3, DATA_WIDTH=8, IMG_WIDTH=4, IMG_HEIGHT=2 unless stated):
- Single row [01,02,03,04] (then row 2 all 00), s_valid always high, pe_ready=1 -> pe_data sequence 0x020100, 0x030201, 0x040302, 0x000403. row_done is asserted with 0x000403.
- Full frame, rows [01..04] and [05..08] -> 8 windows, second row's first window 0x060500, then 2 drain windows 0x000000. frame_done is on the last one, exactly 10 pe_en pulses total.
- pe_ready held low for 3 cycles mid-STREAM -> s_ready=0 and pe_en=0 during the stall. The window sequence is identical to the unstalled run.
- s_valid toggled every other cycle -> same window values, one window per accepted pixel after FILL, no extra pulses.
- rst asserted mid-row 2 for 1 cycle -> next cycle all outputs 0. A new frame then produces the full 10-window sequence from 0x020100.
- With PE_WINDOW_FEEDER_BINARIZE_EN, THRESHOLD=128, row [00,80,7F,FF] -> windows 0x010000, 0x000100, 0x010001, 0x000100.
